// File: rtl/alu_seq_ctrl.sv
// Purpose: key-driven sequencer for the 4-bit ALU datapath (A entry, B entry, opcode, execute, display).
// Latency: key press -> event ~DEBOUNCE_CYCLES+3 clk; capture -> load_a/load_b one cycle later; S_EXEC lasts EXEC_WAIT cycles.
// Backpressure: none; the datapath registers always accept a strobe, and events arriving in S_EXEC (other than cancel) are dropped.
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   key[1:0]           raw active-low buttons, key[0]=advance, key[1]=cancel
//   sw_data, sw_op     operand / opcode switches, sampled only on the capture cycle
//   operand, sel       registered operand and ALU opcode
//   load_a/b/c         one-cycle load strobes for registers A, B, C
//   state, busy        FSM state code for LEDs, high while executing
//   op_count           completed executions, wraps 255 -> 0
module alu_seq_ctrl #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int EXEC_WAIT       = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] key,
    input  logic [3:0] sw_data,
    input  logic [2:0] sw_op,
    output logic [3:0] operand,
    output logic [2:0] sel,
    output logic       load_a,
    output logic       load_b,
    output logic       load_c,
    output logic [2:0] state,
    output logic       busy,
    output logic [7:0] op_count
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int EW = (EXEC_WAIT > 1) ? $clog2(EXEC_WAIT) : 1;
    localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [EW-1:0] EXEC_LAST = EW'(EXEC_WAIT - 1);

    typedef enum logic [2:0] {
        S_A    = 3'd0,
        S_B    = 3'd1,
        S_OP   = 3'd2,
        S_EXEC = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t        cur_st, nxt_st;

    logic [1:0]    sync_q1, sync_q2;
    logic [1:0]    deb_lvl, deb_prev;
    logic [DW-1:0] deb_cnt [2];
    logic          adv_evt, can_evt;

    logic [EW-1:0] exec_cnt, exec_cnt_nxt;
    logic [3:0]    operand_nxt;
    logic [2:0]    sel_nxt;
    logic [7:0]    op_count_nxt;
    logic          pend_a, pend_b, pend_a_nxt, pend_b_nxt;
    logic          load_a_nxt, load_b_nxt, load_c_nxt;

    // Key conditioning: synchronizer, then a level that only flips after
    // DEBOUNCE_CYCLES consecutive samples disagree with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q1  <= 2'b11;
            sync_q2  <= 2'b11;
            deb_lvl  <= 2'b11;
            deb_prev <= 2'b11;
            for (int i = 0; i < 2; i++) begin
                deb_cnt[i] <= '0;
            end
        end else begin
            sync_q1  <= key;
            sync_q2  <= sync_q1;
            deb_prev <= deb_lvl;
            for (int i = 0; i < 2; i++) begin
                if (sync_q2[i] != deb_lvl[i]) begin
                    if (deb_cnt[i] == DEB_LAST) begin
                        deb_cnt[i] <= '0;
                        deb_lvl[i] <= ~deb_lvl[i];
                    end else begin
                        deb_cnt[i] <= deb_cnt[i] + 1'b1;
                    end
                end else begin
                    deb_cnt[i] <= '0;
                end
            end
        end
    end

    // Press = debounced falling edge; releases are ignored.
    assign adv_evt = deb_prev[0] & ~deb_lvl[0];
    assign can_evt = deb_prev[1] & ~deb_lvl[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_st   <= S_A;
            operand  <= '0;
            sel      <= '0;
            exec_cnt <= '0;
            op_count <= '0;
            pend_a   <= 1'b0;
            pend_b   <= 1'b0;
            load_a   <= 1'b0;
            load_b   <= 1'b0;
            load_c   <= 1'b0;
        end else begin
            cur_st   <= nxt_st;
            operand  <= operand_nxt;
            sel      <= sel_nxt;
            exec_cnt <= exec_cnt_nxt;
            op_count <= op_count_nxt;
            pend_a   <= pend_a_nxt;
            pend_b   <= pend_b_nxt;
            load_a   <= load_a_nxt;
            load_b   <= load_b_nxt;
            load_c   <= load_c_nxt;
        end
    end

    always_comb begin
        nxt_st       = cur_st;
        operand_nxt  = operand;
        sel_nxt      = sel;
        exec_cnt_nxt = exec_cnt;
        op_count_nxt = op_count;
        pend_a_nxt   = 1'b0;
        pend_b_nxt   = 1'b0;
        load_c_nxt   = 1'b0;

        if (can_evt) begin
            // Cancel beats advance and kills any strobe due next cycle.
            nxt_st = S_A;
        end else begin
            case (cur_st)
                S_A: begin
                    if (adv_evt) begin
                        operand_nxt = sw_data;
                        pend_a_nxt  = 1'b1;
                        nxt_st      = S_B;
                    end
                end
                S_B: begin
                    if (adv_evt) begin
                        operand_nxt = sw_data;
                        pend_b_nxt  = 1'b1;
                        nxt_st      = S_OP;
                    end
                end
                S_OP: begin
                    if (adv_evt) begin
                        sel_nxt      = sw_op;
                        exec_cnt_nxt = '0;
                        nxt_st       = S_EXEC;
                        // With a one-cycle wait the strobe lands in the first EXEC cycle.
                        load_c_nxt   = (EXEC_LAST == '0);
                    end
                end
                S_EXEC: begin
                    if (exec_cnt == EXEC_LAST) begin
                        // load_c is high in this cycle; the execution counts as complete.
                        op_count_nxt = op_count + 8'd1;
                        nxt_st       = S_DONE;
                    end else begin
                        exec_cnt_nxt = exec_cnt + 1'b1;
                        load_c_nxt   = ((exec_cnt + 1'b1) == EXEC_LAST);
                    end
                end
                S_DONE: begin
                    if (adv_evt) begin
                        nxt_st = S_A;
                    end
                end
                default: begin
                    nxt_st = S_A;
                end
            endcase
        end

        // Strobes trail the operand capture by one cycle so operand is settled.
        load_a_nxt = pend_a & ~can_evt;
        load_b_nxt = pend_b & ~can_evt;
    end

    assign state = cur_st;
    assign busy  = (cur_st == S_EXEC);

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Purpose: self-checking bench for alu_seq_ctrl; strobes are matched against a queue of expected loads.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_alu_seq_ctrl;

    localparam int DEB = 4;
    localparam int EW  = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] key = 2'b11;
    logic [3:0] sw_data = 4'd0;
    logic [2:0] sw_op = 3'd0;
    logic [3:0] operand;
    logic [2:0] sel;
    logic       load_a, load_b, load_c;
    logic [2:0] state;
    logic       busy;
    logic [7:0] op_count;

    always #5 clk = ~clk;

    alu_seq_ctrl #(
        .DEBOUNCE_CYCLES(DEB),
        .EXEC_WAIT      (EW)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .key     (key),
        .sw_data (sw_data),
        .sw_op   (sw_op),
        .operand (operand),
        .sel     (sel),
        .load_a  (load_a),
        .load_b  (load_b),
        .load_c  (load_c),
        .state   (state),
        .busy    (busy),
        .op_count(op_count)
    );

    // kind: one-hot {c,b,a}; dat: {op_count during the strobe, operand or {0,sel}}
    typedef struct packed {
        logic [2:0]  kind;
        logic [11:0] dat;
    } exp_t;

    exp_t       sb_q[$];
    int         total = 0;
    int         bad = 0;
    int         exec_cyc = 0;
    logic [2:0] prev_stb = 3'd0;
    logic [7:0] m_cnt = 8'd0;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [1:0] mask, input int hold);
        key = ~mask;
        tick(hold);
        key = 2'b11;
        tick(10);
    endtask

    task automatic push(input logic [2:0] kind, input logic [3:0] val);
        sb_q.push_back({kind, m_cnt, val});
    endtask

    task automatic run_seq(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op);
        sw_data = a;
        push(3'b001, a);
        press(2'b01, 8);
        sw_data = 4'($urandom);
        sw_data = b;
        push(3'b010, b);
        press(2'b01, 8);
        sw_data = 4'($urandom);
        sw_op = op;
        push(3'b100, {1'b0, op});
        press(2'b01, 8);
        sw_op = 3'($urandom);
        m_cnt = m_cnt + 8'd1;
        press(2'b01, 8);
    endtask

    // Strobe monitor: sampled on the falling edge, away from DUT updates.
    always @(negedge clk) begin
        logic [2:0] stb;
        exp_t       e;
        stb = {load_c, load_b, load_a};
        if (!rst_n) begin
            prev_stb = 3'd0;
            exec_cyc = 0;
        end else begin
            exec_cyc = (state == 3'd3) ? exec_cyc + 1 : 0;
            if (stb != 3'd0) begin
                chk_eq("stb_onehot", $countones(stb), 1);
                chk_eq("stb_width", stb & prev_stb, 0);
                if (sb_q.size() == 0) begin
                    chk_eq("stb_unexpected", stb, 0);
                end else begin
                    e = sb_q.pop_front();
                    chk_eq("stb_kind", stb, e.kind);
                    chk_eq("stb_dat", load_c ? {op_count, 1'b0, sel} : {op_count, operand}, e.dat);
                    if (load_c) begin
                        chk_eq("c_latency", exec_cyc, EW);
                        chk_eq("busy_in_exec", busy, 1);
                    end
                end
            end
            prev_stb = stb;
        end
    end

    initial begin
        repeat (80000) @(posedge clk);
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    initial begin
        bit found;

        // Reset values
        tick(3);
        chk_eq("rst_state", state, 0);
        chk_eq("rst_operand", operand, 0);
        chk_eq("rst_sel", sel, 0);
        chk_eq("rst_strobes", {load_c, load_b, load_a}, 0);
        chk_eq("rst_busy", busy, 0);
        chk_eq("rst_opcnt", op_count, 0);
        rst_n = 1'b1;
        tick(3);

        // Full A/B/OP/EXEC sequence
        sw_data = 4'd5;
        push(3'b001, 4'd5);
        press(2'b01, 10);
        sw_data = 4'd14;
        chk_eq("seq_state_b", state, 1);
        chk_eq("seq_operand_a", operand, 5);
        sw_data = 4'd3;
        push(3'b010, 4'd3);
        press(2'b01, 10);
        sw_data = 4'd8;
        chk_eq("seq_state_op", state, 2);
        chk_eq("seq_operand_b", operand, 3);
        sw_op = 3'd2;
        push(3'b100, 4'd2);
        press(2'b01, 10);
        sw_op = 3'd7;
        m_cnt = m_cnt + 8'd1;
        chk_eq("seq_state_done", state, 4);
        chk_eq("seq_sel", sel, 2);
        chk_eq("seq_opcnt", op_count, 1);
        chk_eq("seq_busy_done", busy, 0);
        press(2'b01, 10);
        chk_eq("seq_back_to_a", state, 0);
        chk_eq("seq_hold_operand", operand, 3);

        // Bouncing advance key: one event only
        sw_data = 4'd9;
        push(3'b001, 4'd9);
        for (int i = 0; i < 5; i++) begin
            key[0] = 1'b0;
            tick(2);
            key[0] = 1'b1;
            tick(2);
        end
        key[0] = 1'b0;
        tick(10);
        key[0] = 1'b1;
        tick(10);
        sw_data = 4'd1;
        chk_eq("bounce_state", state, 1);
        chk_eq("bounce_operand", operand, 9);

        // Cancel in the second EXEC cycle
        sw_data = 4'd7;
        push(3'b010, 4'd7);
        press(2'b01, 8);
        chk_eq("cx_state_op", state, 2);
        sw_op = 3'd6;
        key[0] = 1'b0;
        tick(2);
        key[1] = 1'b0;
        tick(10);
        key = 2'b11;
        tick(10);
        sw_op = 3'd1;
        chk_eq("cx_state", state, 0);
        chk_eq("cx_opcnt", op_count, m_cnt);
        chk_eq("cx_sel", sel, 6);
        chk_eq("cx_operand", operand, 7);

        // Advance and cancel together in S_B
        sw_data = 4'd4;
        push(3'b001, 4'd4);
        press(2'b01, 8);
        chk_eq("both_state_b", state, 1);
        sw_data = 4'd11;
        press(2'b11, 8);
        chk_eq("both_state", state, 0);
        chk_eq("both_operand", operand, 4);

        // op_count wrap
        for (int i = 0; i < 254; i++) begin
            run_seq(4'($urandom), 4'($urandom), 3'($urandom));
        end
        chk_eq("wrap_255", op_count, 255);
        run_seq(4'd10, 4'd6, 3'd5);
        chk_eq("wrap_0", op_count, 0);
        chk_eq("wrap_state", state, 0);

        // Reset during the load_b cycle
        sw_data = 4'd12;
        push(3'b001, 4'd12);
        press(2'b01, 8);
        sw_data = 4'd13;
        push(3'b010, 4'd13);
        key[0] = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (load_b) found = 1'b1;
        end
        chk_eq("lb_seen", found, 1);
        #1;
        rst_n = 1'b0;
        key = 2'b11;
        #1;
        chk_eq("mr_load_b", load_b, 0);
        chk_eq("mr_state", state, 0);
        chk_eq("mr_operand", operand, 0);
        chk_eq("mr_sel", sel, 0);
        chk_eq("mr_opcnt", op_count, 0);
        m_cnt = 8'd0;
        tick(3);
        rst_n = 1'b1;
        tick(20);
        chk_eq("post_rst_state", state, 0);
        chk_eq("sb_empty", sb_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
